// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around a one-bit full-adder cell
// with a registered carry. Operands are captured on an accepted start and
// consumed LSB-first, one bit per clock. The sum bits are gathered into a
// parallel result, and a one-cycle done pulse marks each new result.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only in IDLE or FIN
//   a, b   - operands, captured when start is accepted
//   cin    - initial carry-in, captured with a/b
//   busy   - high while bits are being processed (RUN)
//   done   - one-cycle pulse: sum/cout newly valid
//   sum    - registered result a+b+cin, modulo 2^WIDTH
//   cout   - registered carry out of bit WIDTH-1
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter must be able to hold WIDTH, the value it reaches on the exit edge.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rs_next;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;

  // One-bit full-adder cell. The stored carry is fed back as carry-in.
  assign s = ra[0] ^ rb[0] ^ cy;
  assign c = (ra[0] & rb[0]) | (cy & (ra[0] ^ rb[0]));

  // The sum register fills from the MSB. After WIDTH shifts the first bit
  // produced (the LSB) has reached bit 0. Shifting and then overwriting the top
  // bit also covers WIDTH=1 without a special case.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    rs_next            = rs >> 1;
    rs_next[WIDTH-1]   = s;
  end

  // NOTE: all sequential state uses non-blocking assignments, so each register samples pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // FIN accepts start exactly like IDLE, so back-to-back operations
        // complete one result every WIDTH+1 cycles.
        IDLE, FIN: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            cy    <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        // start is not examined here. Requests during RUN are dropped.
        RUN: begin
          rs  <= rs_next;
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          cy  <= c;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= rs_next;
            cout  <= c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. It drives a WIDTH=8 instance with
// directed and random operations, and a WIDTH=1 instance with every
// full-adder input combination. Expected results come from plain
// integer addition.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8;
  logic [7:0] sum8;
  logic       cout8;

  logic start1, a1, b1, cin1;
  logic busy1, done1, sum1, cout1;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned last_done_cyc = 0;

  // Last result the WIDTH=8 instance is expected to be holding.
  logic [7:0] exp8_sum = 8'h00;
  logic       exp8_cout = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start1),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1),
    .cout (cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 9-bit sum of the two operands and the carry-in.
  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[8:0];
  endfunction

  // Starts one operation on the 8-bit instance and waits (bounded) for done.
  // Called with the clock 1 time unit past a rising edge. It returns in the
  // done cycle with start low. poke_n >= 0 re-asserts start with 0xFF/0xFF
  // for one cycle at that RUN cycle index, and that request must be ignored.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input int poke_n);
    logic [8:0] r;
    int         n;
    int         bc;
    bit         held;
    r = ref_add(x, y, c);
    start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    n = 0; bc = 0; held = 1'b1;
    while (!done8 && n < 32) begin
      if (busy8) bc++;
      if (sum8 !== exp8_sum || cout8 !== exp8_cout) held = 1'b0;
      if (n == poke_n) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start8 = 1'b0;
    last_done_cyc = cyc;
    check("latency", n, 8);
    check("busy_cycles", bc, 8);
    check("sum_held_during_run", held, 1);
    check("busy_low_at_done", busy8, 0);
    check("done", done8, 1);
    check("sum", sum8, r[7:0]);
    check("cout", cout8, r[8]);
    exp8_sum = r[7:0];
    exp8_cout = r[8];
  endtask

  task automatic idle8(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      check("idle_done_low", done8, 0);
      check("idle_busy_low", busy8, 0);
      check("idle_sum_held", sum8, exp8_sum);
    end
  endtask

  task automatic op1(input logic x, input logic y, input logic c);
    logic [1:0] r;
    r = 2'(int'(x) + int'(y) + int'(c));
    start1 = 1'b1; a1 = x; b1 = y; cin1 = c;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    check("w1_busy", busy1, 1);
    check("w1_done_early", done1, 0);
    @(posedge clk); #1;
    check("w1_done", done1, 1);
    check("w1_busy_at_done", busy1, 0);
    check("w1_sum", sum1, r[0]);
    check("w1_cout", cout1, r[1]);
    @(posedge clk); #1;
    check("w1_done_pulse", done1, 0);
  endtask

  initial begin
    int unsigned prev_done;
    bit          saw_done;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #12;
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_w1_sum", sum1, 0);
    check("rst_w1_done", done1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    op8(8'h0F, 8'h01, 1'b0, -1);
    idle8(1);
    op8(8'hFF, 8'h01, 1'b0, -1);
    idle8(1);
    op8(8'hFF, 8'hFF, 1'b1, -1);
    idle8(1);
    op8(8'h12, 8'h34, 1'b0, 2);
    idle8(2);

    // Start held through the done cycle: the second operation starts at once.
    op8(8'h80, 8'h80, 1'b0, -1);
    prev_done = last_done_cyc;
    op8(8'h80, 8'h80, 1'b0, -1);
    check("b2b_done_spacing", last_done_cyc - prev_done, 9);
    idle8(1);

    // Reset in the middle of RUN discards the operation.
    op8(8'h12, 8'h34, 1'b0, -1);
    idle8(1);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_sum", sum8, 0);
    check("midrst_cout", cout8, 0);
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    exp8_sum = 8'h00;
    exp8_cout = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("no_activity_after_reset", saw_done, 0);
    op8(8'h01, 8'h01, 1'b0, -1);
    idle8(1);

    // Random operations with random gaps (gap 0 gives back-to-back starts).
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), -1);
      idle8(int'($urandom_range(0, 2)));
    end

    // WIDTH=1: full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
